// File: rtl/uart_pkg.sv
// Shared definitions for the UART transmit path and the planned receiver.
package uart_pkg;

  localparam int unsigned PARITY_NONE = 0;
  localparam int unsigned PARITY_ODD  = 1;
  localparam int unsigned PARITY_EVEN = 2;

  typedef enum logic [2:0] {
    StIdle,
    StStart,
    StData,
    StParity,
    StStop
  } uart_tx_state_t;

  // Number of bit periods in one frame: start + payload + optional parity + stop bits.
  function automatic int unsigned frame_bits(input int unsigned data_bits,
                                             input int unsigned parity,
                                             input int unsigned stop_bits);
    return 1 + data_bits + ((parity != PARITY_NONE) ? 1 : 0) + stop_bits;
  endfunction

endpackage

// File: rtl/uart_sync_fifo.sv
// Single-clock FIFO; pointers carry one extra wrap bit to tell full from empty.
module uart_sync_fifo #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     push,
  input  logic [WIDTH-1:0]         wdata,
  input  logic                     pop,
  output logic [WIDTH-1:0]         rdata,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   level
);

  localparam int unsigned AW = $clog2(DEPTH);

  if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0) begin : gen_bad_depth
    $error("uart_sync_fifo: DEPTH must be a power of two and >= 2");
  end

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW:0]      wr_ptr_q, rd_ptr_q;
  logic             do_push, do_pop;

  assign full    = (wr_ptr_q[AW] != rd_ptr_q[AW]) && (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
  assign empty   = (wr_ptr_q == rd_ptr_q);
  assign level   = wr_ptr_q - rd_ptr_q;
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign rdata   = mem_q[rd_ptr_q[AW-1:0]];

  // Pointer update; a push into a full FIFO is silently dropped.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      if (do_push) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (do_pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
    end
  end

  // Storage write; contents need no reset since the pointers gate visibility.
  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q[AW-1:0]] <= wdata;
  end

endmodule

// File: rtl/uart_tx_fifo_param.sv
// UART transmitter with a transmit FIFO; frames go out back-to-back while data is queued.
module uart_tx_fifo_param
  import uart_pkg::*;
#(
  parameter int unsigned CLK_FREQ   = 50000000,
  parameter int unsigned BAUD_RATE  = 9600,
  parameter int unsigned DATA_BITS  = 8,
  parameter int unsigned PARITY     = 0,
  parameter int unsigned STOP_BITS  = 1,
  parameter int unsigned FIFO_DEPTH = 4
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          s_valid,
  output logic                          s_ready,
  input  logic [DATA_BITS-1:0]          s_data,
  output logic                          tx_line,
  output logic                          tx_busy,
  output logic                          tx_done,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_level
);

  localparam int unsigned CLKS_PER_BIT = CLK_FREQ / BAUD_RATE;
  localparam int unsigned BAUD_W       = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;

  if (CLKS_PER_BIT < 2) begin : gen_bad_cpb
    $error("uart_tx_fifo_param: CLK_FREQ/BAUD_RATE must be >= 2");
  end
  if (DATA_BITS < 5 || DATA_BITS > 9) begin : gen_bad_data_bits
    $error("uart_tx_fifo_param: DATA_BITS must be 5..9");
  end
  if (PARITY > PARITY_EVEN) begin : gen_bad_parity
    $error("uart_tx_fifo_param: PARITY must be 0, 1 or 2");
  end
  if (STOP_BITS < 1 || STOP_BITS > 2) begin : gen_bad_stop_bits
    $error("uart_tx_fifo_param: STOP_BITS must be 1 or 2");
  end

  uart_tx_state_t         state_q, state_d;
  logic [BAUD_W-1:0]      baud_q, baud_d;
  logic [3:0]             bit_q, bit_d;
  logic [DATA_BITS-1:0]   shift_q, shift_d;
  logic                   par_q, par_d;
  logic                   tx_q, tx_d;
  logic                   done_q, done_d;
  logic                   bit_end, load;
  logic                   fifo_pop, fifo_full, fifo_empty;
  logic [DATA_BITS-1:0]   fifo_rdata;

  uart_sync_fifo #(
    .WIDTH (DATA_BITS),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk   (clk),
    .reset (reset),
    .push  (s_valid),
    .wdata (s_data),
    .pop   (fifo_pop),
    .rdata (fifo_rdata),
    .full  (fifo_full),
    .empty (fifo_empty),
    .level (fifo_level)
  );

  assign bit_end = (baud_q == BAUD_W'(CLKS_PER_BIT - 1));

  // Next-state logic: each bit lasts one baud-counter wrap; 'load' starts a new frame.
  always_comb begin
    state_d  = state_q;
    baud_d   = bit_end ? '0 : baud_q + 1'b1;
    bit_d    = bit_q;
    shift_d  = shift_q;
    par_d    = par_q;
    tx_d     = tx_q;
    done_d   = 1'b0;
    load     = 1'b0;
    fifo_pop = 1'b0;
    unique case (state_q)
      StIdle: begin
        baud_d = '0;
        load   = !fifo_empty;
      end
      StStart: begin
        if (bit_end) begin
          state_d = StData;
          bit_d   = '0;
          tx_d    = shift_q[0];
        end
      end
      StData: begin
        if (bit_end) begin
          if (bit_q == 4'(DATA_BITS - 1)) begin
            bit_d = '0;
            if (PARITY != PARITY_NONE) begin
              state_d = StParity;
              tx_d    = par_q;
            end else begin
              state_d = StStop;
              tx_d    = 1'b1;
            end
          end else begin
            bit_d   = bit_q + 4'd1;
            shift_d = shift_q >> 1;
            tx_d    = shift_q[1];
          end
        end
      end
      StParity: begin
        if (bit_end) begin
          state_d = StStop;
          tx_d    = 1'b1;
        end
      end
      StStop: begin
        if (bit_end) begin
          if (bit_q == 4'(STOP_BITS - 1)) begin
            done_d = 1'b1;
            bit_d  = '0;
            if (!fifo_empty) begin
              load = 1'b1;
            end else begin
              state_d = StIdle;
              tx_d    = 1'b1;
            end
          end else begin
            bit_d = bit_q + 4'd1;
          end
        end
      end
      default: state_d = StIdle;
    endcase
    // Pop and drive the start bit on the same edge, so back-to-back frames have no gap.
    if (load) begin
      fifo_pop = 1'b1;
      shift_d  = fifo_rdata;
      par_d    = (PARITY == PARITY_ODD) ? ~^fifo_rdata : ^fifo_rdata;
      tx_d     = 1'b0;
      baud_d   = '0;
      state_d  = StStart;
    end
  end

  // State registers; the line idles high and returns high at once on reset.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= StIdle;
      baud_q  <= '0;
      bit_q   <= '0;
      shift_q <= '0;
      par_q   <= 1'b0;
      tx_q    <= 1'b1;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      baud_q  <= baud_d;
      bit_q   <= bit_d;
      shift_q <= shift_d;
      par_q   <= par_d;
      tx_q    <= tx_d;
      done_q  <= done_d;
    end
  end

  assign tx_line = tx_q;
  assign tx_busy = (state_q != StIdle);
  assign tx_done = done_q;
  assign s_ready = !fifo_full;

endmodule

// File: tb/tb_uart_tx_fifo_param.sv
// Bench: four transmitter configurations (8N1, 8E1, 8O1, 7N2) at 10 clocks per bit.
module tb_uart_tx_fifo_param;

  localparam int CPB   = 10;
  localparam int DEPTH = 4;

  logic       clk = 1'b0;
  logic       reset;
  logic       s_valid    [4];
  logic [8:0] s_data     [4];
  logic       s_ready    [4];
  logic       tx_line    [4];
  logic       tx_busy    [4];
  logic       tx_done    [4];
  logic [2:0] fifo_level [4];

  int vectors     = 0;
  int miscompares = 0;

  always #5 clk = ~clk;

  uart_tx_fifo_param #(.CLK_FREQ(100), .BAUD_RATE(10), .DATA_BITS(8), .PARITY(0),
                       .STOP_BITS(1), .FIFO_DEPTH(DEPTH)) u_8n1 (
    .clk(clk), .reset(reset), .s_valid(s_valid[0]), .s_ready(s_ready[0]),
    .s_data(s_data[0][7:0]), .tx_line(tx_line[0]), .tx_busy(tx_busy[0]),
    .tx_done(tx_done[0]), .fifo_level(fifo_level[0]));

  uart_tx_fifo_param #(.CLK_FREQ(100), .BAUD_RATE(10), .DATA_BITS(8), .PARITY(2),
                       .STOP_BITS(1), .FIFO_DEPTH(DEPTH)) u_8e1 (
    .clk(clk), .reset(reset), .s_valid(s_valid[1]), .s_ready(s_ready[1]),
    .s_data(s_data[1][7:0]), .tx_line(tx_line[1]), .tx_busy(tx_busy[1]),
    .tx_done(tx_done[1]), .fifo_level(fifo_level[1]));

  uart_tx_fifo_param #(.CLK_FREQ(100), .BAUD_RATE(10), .DATA_BITS(8), .PARITY(1),
                       .STOP_BITS(1), .FIFO_DEPTH(DEPTH)) u_8o1 (
    .clk(clk), .reset(reset), .s_valid(s_valid[2]), .s_ready(s_ready[2]),
    .s_data(s_data[2][7:0]), .tx_line(tx_line[2]), .tx_busy(tx_busy[2]),
    .tx_done(tx_done[2]), .fifo_level(fifo_level[2]));

  uart_tx_fifo_param #(.CLK_FREQ(100), .BAUD_RATE(10), .DATA_BITS(7), .PARITY(0),
                       .STOP_BITS(2), .FIFO_DEPTH(DEPTH)) u_7n2 (
    .clk(clk), .reset(reset), .s_valid(s_valid[3]), .s_ready(s_ready[3]),
    .s_data(s_data[3][6:0]), .tx_line(tx_line[3]), .tx_busy(tx_busy[3]),
    .tx_done(tx_done[3]), .fifo_level(fifo_level[3]));

  // Configuration of each instance, as the bench understands it.
  function automatic int db_of(input int i);
    return (i == 3) ? 7 : 8;
  endfunction
  function automatic int par_of(input int i);
    return (i == 1) ? 2 : (i == 2) ? 1 : 0;
  endfunction
  function automatic int sb_of(input int i);
    return (i == 3) ? 2 : 1;
  endfunction
  function automatic int nb_of(input int i);
    return 1 + db_of(i) + ((par_of(i) != 0) ? 1 : 0) + sb_of(i);
  endfunction

  // Expected line level during bit k of the frame carrying word w on instance i.
  function automatic logic exp_bit(input int i, input logic [8:0] w, input int k);
    logic p;
    if (k == 0) return 1'b0;
    if (k <= db_of(i)) return w[k-1];
    if (par_of(i) != 0 && k == db_of(i) + 1) begin
      p = 1'b0;
      for (int j = 0; j < db_of(i); j++) p = p ^ w[j];
      return (par_of(i) == 1) ? ~p : p;
    end
    return 1'b1;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic push_one(input int i, input logic [8:0] d);
    @(negedge clk);
    s_valid[i] = 1'b1;
    s_data[i]  = d;
    @(negedge clk);
    s_valid[i] = 1'b0;
  endtask

  typedef struct {
    int          inst;
    logic [8:0]  data;
    int          nbits;
    logic [11:0] frame;   // bit k = line level during bit period k
  } vec_t;

  // Push one word into an idle instance and check the whole frame it produces.
  task automatic apply_vec(input vec_t v);
    int          i;
    logic [11:0] pat;
    logic        stable, early;
    i      = v.inst;
    pat    = '0;
    stable = 1'b1;
    early  = 1'b0;
    push_one(i, v.data);
    check("level_after_push", 32'(fifo_level[i]), 1);
    check("line_idle_after_push", 32'(tx_line[i]), 1);
    @(negedge clk);
    check("start_at_pop_edge", {29'd0, tx_line[i], tx_busy[i], fifo_level[i] == 3'd0}, 3'b011);
    for (int k = 0; k < v.nbits * CPB; k++) begin
      if (k > 0) @(negedge clk);
      if (k % CPB == 0) pat[k/CPB] = tx_line[i];
      else if (tx_line[i] !== pat[k/CPB]) stable = 1'b0;
      if (tx_done[i]) early = 1'b1;
    end
    @(negedge clk);
    check("done_at_frame_end", 32'(tx_done[i]), 1);
    check("frame_pattern", 32'(pat), 32'(v.frame));
    check("bits_held_full_period", 32'(stable), 1);
    check("no_early_done", 32'(early), 0);
    repeat (3) @(negedge clk);
  endtask

  // Random pushes on instance i, compared cycle by cycle with a queue-based model.
  task automatic rand_test(input int i, input int cycles);
    logic [8:0] q[$];
    logic [8:0] cur_w, d;
    logic       v, exp_done, pre_nonempty, pre_ready, exp_line;
    logic [6:0] exp_o, act_o;
    int         rem, flen, dens;
    rem      = 0;
    cur_w    = '0;
    exp_done = 1'b0;
    flen     = nb_of(i) * CPB;
    for (int c = 0; c < cycles + (DEPTH + 2) * flen; c++) begin
      @(negedge clk);
      exp_line = (rem > 0) ? exp_bit(i, cur_w, (flen - rem) / CPB) : 1'b1;
      exp_o = {exp_line, rem > 0, exp_done, q.size() < DEPTH, 3'(q.size())};
      act_o = {tx_line[i], tx_busy[i], tx_done[i], s_ready[i], fifo_level[i]};
      check("random_outputs", 32'(act_o), 32'(exp_o));
      dens = ((c / 200) % 2 == 0) ? 60 : 5;
      v = (c < cycles) && ($urandom_range(0, 99) < dens);
      d = 9'($urandom);
      s_valid[i]   = v;
      s_data[i]    = d;
      pre_nonempty = (q.size() > 0);
      pre_ready    = (q.size() < DEPTH);
      @(posedge clk);
      exp_done = 1'b0;
      if (rem > 0) begin
        rem--;
        if (rem == 0) exp_done = 1'b1;
      end
      if (rem == 0 && pre_nonempty) begin
        cur_w = q.pop_front();
        rem   = flen;
      end
      if (v && pre_ready) q.push_back(d);
    end
    s_valid[i] = 1'b0;
  endtask

  vec_t       tbl [6];
  logic [8:0] words [6];

  initial begin
    int   done_cnt, last_done, rel;
    logic line_err, busy_gap, bad;

    tbl[0] = '{inst: 0, data: 9'h0A5, nbits: 10, frame: 12'h34A};  // 8N1
    tbl[1] = '{inst: 1, data: 9'h0A5, nbits: 11, frame: 12'h54A};  // 8E1, parity 0
    tbl[2] = '{inst: 2, data: 9'h0A5, nbits: 11, frame: 12'h74A};  // 8O1, parity 1
    tbl[3] = '{inst: 2, data: 9'h007, nbits: 11, frame: 12'h40E};  // 8O1, parity 0
    tbl[4] = '{inst: 1, data: 9'h007, nbits: 11, frame: 12'h60E};  // 8E1, parity 1
    tbl[5] = '{inst: 3, data: 9'h1FF, nbits: 10, frame: 12'h3FE};  // 7N2
    words  = '{9'h0C3, 9'h05A, 9'h0FF, 9'h001, 9'h080, 9'h0EE};

    reset = 1'b1;
    for (int i = 0; i < 4; i++) begin
      s_valid[i] = 1'b0;
      s_data[i]  = '0;
    end
    repeat (2) @(negedge clk);
    for (int i = 0; i < 4; i++)
      check("reset_values", {25'd0, tx_line[i], tx_busy[i], tx_done[i], s_ready[i],
                             fifo_level[i]}, 7'b1001_000);
    reset = 1'b0;
    repeat (2) @(negedge clk);

    foreach (tbl[n]) apply_vec(tbl[n]);

    // FIFO depth 4: six words offered on consecutive edges; the sixth must be dropped.
    @(negedge clk);
    s_valid[0] = 1'b1;
    for (int w = 0; w < 6; w++) begin
      s_data[0] = words[w];
      @(negedge clk);
      check("fill_level", 32'(fifo_level[0]), (w == 0) ? 1 : (w >= 4) ? 4 : w);
      check("fill_ready", 32'(s_ready[0]), (w >= 4) ? 0 : 1);
    end
    s_valid[0] = 1'b0;
    done_cnt = 0;
    last_done = 0;
    line_err = 1'b0;
    busy_gap = 1'b0;
    for (int t = 5; t <= 700; t++) begin
      if (t > 5) @(negedge clk);
      rel = t - 1;
      if (tx_done[0]) begin
        done_cnt++;
        last_done = t;
      end
      if (rel < 500) begin
        if (tx_line[0] !== exp_bit(0, words[rel/100], (rel % 100) / CPB)) line_err = 1'b1;
        if (!tx_busy[0]) busy_gap = 1'b1;
      end else if (tx_line[0] !== 1'b1) line_err = 1'b1;
    end
    check("burst_done_count", 32'(done_cnt), 5);
    check("burst_last_done_cycle", 32'(last_done), 501);
    check("burst_line", 32'(line_err), 0);
    check("burst_busy_gap", 32'(busy_gap), 0);
    check("burst_level_drained", 32'(fifo_level[0]), 0);

    // Reset in the middle of the 2nd of three queued frames.
    @(negedge clk);
    s_valid[0] = 1'b1;
    s_data[0]  = 9'h011;
    @(negedge clk);
    s_data[0]  = 9'h00F;
    @(negedge clk);
    s_data[0]  = 9'h0AA;
    @(negedge clk);
    s_valid[0] = 1'b0;
    repeat (153) @(negedge clk);
    check("pre_reset_line_low", {30'd0, tx_line[0], fifo_level[0] == 3'd1}, 2'b01);
    reset = 1'b1;
    #1;
    check("async_reset_outputs", {25'd0, tx_line[0], tx_busy[0], tx_done[0], s_ready[0],
                                  fifo_level[0]}, 7'b1001_000);
    @(negedge clk);
    reset = 1'b0;
    bad = 1'b0;
    repeat (400) begin
      @(negedge clk);
      if (tx_done[0] || tx_busy[0] || !tx_line[0]) bad = 1'b1;
    end
    check("quiet_after_reset", 32'(bad), 0);

    // Push on the very edge that ends the final stop bit of an otherwise empty FIFO.
    push_one(0, 9'h0C3);
    repeat (100) @(negedge clk);
    s_valid[0] = 1'b1;
    s_data[0]  = 9'h05A;
    @(negedge clk);
    s_valid[0] = 1'b0;
    check("stop_edge_push_done", {28'd0, tx_line[0], tx_busy[0], tx_done[0],
                                  fifo_level[0] == 3'd1}, 4'b1011);
    @(negedge clk);
    check("stop_edge_push_start", {28'd0, tx_line[0], tx_busy[0], tx_done[0],
                                   fifo_level[0] == 3'd0}, 4'b0101);
    last_done = -1;
    for (int k = 1; k <= 200; k++) begin
      @(negedge clk);
      if (tx_done[0] && last_done < 0) last_done = k;
    end
    check("stop_edge_push_frame_len", 32'(last_done), 100);

    for (int i = 0; i < 4; i++) rand_test(i, 800);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/uart_tx_fifo_param.md
# uart_tx_fifo_param

Parametrised UART transmitter with an internal transmit FIFO and a valid/ready input handshake. It serialises configurable 5–9-bit words with optional parity and 1 or 2 stop bits at a compile-time baud rate. Frames are sent back-to-back with no idle gap while the FIFO holds data. It replaces the fixed 8N1 single-word transmitter in the serial subsystem and sits between the host bus bridge and the pad.

## Interface
- CLK_FREQ, 50000000, system clock frequency in Hz
- BAUD_RATE, 9600, line rate in bit/s; CLKS_PER_BIT = CLK_FREQ/BAUD_RATE (integer division) and must be >= 2
- DATA_BITS, 8, payload width, legal range 5..9
- PARITY, 0, parity mode: 0 none, 1 odd, 2 even
- STOP_BITS, 1, number of stop bits, 1 or 2
- FIFO_DEPTH, 4, FIFO entries; must be a power of two, >= 2
- clk  in  1  system clock
- reset  in  1  asynchronous, active-high
- s_valid  in  1  write request
- s_ready  out  1  FIFO can accept a word (= !full)
- s_data  in  DATA_BITS  word to send, LSB transmitted first
- tx_line  out  1  serial output, idle high
- tx_busy  out  1  a frame is on the line
- tx_done  out  1  one-cycle pulse at the end of each frame
- fifo_level  out  $clog2(FIFO_DEPTH)+1  current FIFO occupancy

## Operation
- Push: a word is written on an edge where s_valid && s_ready. s_data is ignored otherwise.
- Frame layout: start bit (0), DATA_BITS payload bits LSB first, an optional parity bit, then STOP_BITS stop bits (1).
- Parity bit: odd mode sends ~^data; even mode sends ^data.
- FSM states: IDLE, START, DATA, PARITY, STOP.
  - IDLE -> START when the FIFO is non-empty. On that edge the block pops the FIFO, loads the shift register, drives tx_line low and clears the baud counter.
  - START -> DATA after CLKS_PER_BIT cycles.
  - DATA -> PARITY (PARITY != 0) or STOP, after DATA_BITS bit periods.
  - PARITY -> STOP after one bit period.
  - STOP -> START if the FIFO is non-empty (pop on the same edge, no idle gap); otherwise STOP -> IDLE. This happens after STOP_BITS bit periods.
- Bit periods: every bit is held exactly CLKS_PER_BIT cycles. The baud counter is $clog2(CLKS_PER_BIT) bits wide and wraps at CLKS_PER_BIT-1. The bit counter is 4 bits wide.
- tx_busy is high in START, DATA, PARITY and STOP, and low in IDLE.
- tx_done is a one-cycle pulse on the edge that ends the last stop bit, including the back-to-back case.
- Simultaneous push and pop on one edge: occupancy is unchanged and s_ready stays high.
- Full FIFO: s_ready is low and the push is dropped by the protocol, so no data is corrupted.
- A push into an empty FIFO is popped no earlier than the following edge.
- Reset values: tx_line 1, tx_busy 0, tx_done 0, s_ready 1, fifo_level 0, state IDLE, FIFO pointers 0.
- Reset asserted mid-frame: tx_line returns high immediately (asynchronous) and all queued words are discarded. No tx_done pulse is produced for the aborted frame.

## Timing
- Push at edge N into an empty FIFO with the block in IDLE: pop occurs at edge N+1, where tx_line falls and tx_busy rises.
- Frame length: (1 + DATA_BITS + (PARITY!=0) + STOP_BITS) × CLKS_PER_BIT cycles, measured from the falling edge of tx_line to the tx_done edge.
- Back-to-back frames: the next start bit begins on the same edge as tx_done. tx_busy stays high throughout.
- s_ready and fifo_level are registered and reflect state after the current edge. There is no combinational path from s_valid to s_ready.

## Structure
- Package uart_pkg holds:
  - the parity mode constants PARITY_NONE/ODD/EVEN
  - the FSM state enum uart_tx_state_t
  - a helper function for the frame length in bits
- Sub-module uart_sync_fifo is a single-clock FIFO with parameters WIDTH and DEPTH. It provides push/pop, full/empty and level outputs, and keeps an extra pointer bit for the full/empty distinction. It is reused by the planned receiver.
- Parameter legality (CLKS_PER_BIT >= 2, DATA_BITS range, power-of-two depth) is checked at elaboration time.

## Test plan
- 8N1, CLK_FREQ=100, BAUD_RATE=10 (10 clocks per bit): push 0xA5. tx_line must show 0,1,0,1,0,0,1,0,1,1, each bit 10 cycles. tx_done must pulse exactly 100 cycles after the line falls.
- 8E1 vs 8O1: push 0xA5 (four ones). The parity bit must be 0 for even and 1 for odd. Push 0x07: the parity bit must be 0 for odd and 1 for even.
- 7N2: push 0x7F. The frame must be 10 bits, the upper s_data bits must be ignored, and the line must stay high for the 20 stop-bit cycles.
- FIFO_DEPTH=4:
  - Push 5 words continuously. s_ready must drop after the 5th, since one word is popped at N+1 and four are queued.
  - All words must be sent back-to-back with no high gap beyond the stop bits.
  - There must be 5 tx_done pulses.
  - fifo_level must count down to 0.
- Assert reset halfway through the DATA bits of the 2nd of 3 queued frames. tx_line must go high in the same cycle, fifo_level must read 0, and no further frame or tx_done may follow.
- Push into an empty FIFO on the same edge as the final stop bit ends. The new frame's start bit must begin exactly one cycle after tx_done.
